// File: rtl/cpu_isa_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : cpu_isa_pkg                                            |
// | Description : Shared ISA definitions for the pipelined CPU: opcode   |
// |               constants, instruction/PC widths and the fetch-stage   |
// |               state encoding.                                        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package cpu_isa_pkg;

   localparam int ISA_INSTR_WIDTH  = 9;
   localparam int ISA_PC_WIDTH     = 16;
   localparam int ISA_OPCODE_WIDTH = 5;

   // Opcode field is the 5 MSBs of the instruction; the 4 LSBs are the operand.
   localparam logic [ISA_OPCODE_WIDTH-1:0] OP_ADD           = 5'b00000;
   localparam logic [ISA_OPCODE_WIDTH-1:0] OP_SUB           = 5'b00001;
   localparam logic [ISA_OPCODE_WIDTH-1:0] OP_AND           = 5'b00010;
   localparam logic [ISA_OPCODE_WIDTH-1:0] OP_OR            = 5'b00011;
   localparam logic [ISA_OPCODE_WIDTH-1:0] OP_SETI          = 5'b01100;
   localparam logic [ISA_OPCODE_WIDTH-1:0] OP_MATH_TO_ADR   = 5'b10010;
   localparam logic [ISA_OPCODE_WIDTH-1:0] OP_JUMP          = 5'b11000;
   localparam logic [ISA_OPCODE_WIDTH-1:0] OP_HALT          = 5'b11010;
   localparam logic [ISA_OPCODE_WIDTH-1:0] OP_TO_BE_DEFINED = 5'b11111;

   typedef enum logic [0:0] {
      FS_RUN    = 1'b0,
      FS_HALTED = 1'b1
   } fetch_state_e;

endpackage : cpu_isa_pkg
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : if_id_reg                                              |
// | Description : IF/ID pipeline register with load / hold / flush.      |
// |               flush has priority over load; with neither asserted    |
// |               the register holds.                                    |
// | Ports       : clk, reset (async, active-high)                        |
// |               load_i, flush_i        - control                       |
// |               instr_i, pc_i          - fetched instruction / address |
// |               instr_o, pc_o, valid_o - registered IF/ID contents     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module if_id_reg #(
   parameter int INSTR_WIDTH = 9,
   parameter int PC_WIDTH    = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load_i,
   input  logic                   flush_i,
   input  logic [INSTR_WIDTH-1:0] instr_i,
   input  logic [PC_WIDTH-1:0]    pc_i,
   output logic [INSTR_WIDTH-1:0] instr_o,
   output logic [PC_WIDTH-1:0]    pc_o,
   output logic                   valid_o
);

   logic [INSTR_WIDTH-1:0] instr_q;
   logic [PC_WIDTH-1:0]    pc_q;
   logic                   valid_q;

   // A bubble keeps the last id_pc; only instr/valid are cleared.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr_q <= '0;
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else if (flush_i) begin
         instr_q <= '0;
         valid_q <= 1'b0;
      end else if (load_i) begin
         instr_q <= instr_i;
         pc_q    <= pc_i;
         valid_q <= 1'b1;
      end
   end

   assign instr_o = instr_q;
   assign pc_o    = pc_q;
   assign valid_o = valid_q;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : instruction_fetch                                      |
// | Description : Fetch stage. Owns the PC, drives the instruction ROM,  |
// |               registers the returned instruction into IF/ID, and     |
// |               handles stall, redirect and halt detection.            |
// | Ports       : clk, reset (async, active-high)                        |
// |               rom_pc / rom_instr      - ROM address / data           |
// |               stall, redirect, redirect_pc - pipeline control        |
// |               id_instr, id_pc, id_valid    - IF/ID register          |
// |               halted, fetch_count          - status                  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module instruction_fetch
   import cpu_isa_pkg::*;
#(
   parameter int                     PC_WIDTH     = ISA_PC_WIDTH,
   parameter int                     INSTR_WIDTH  = ISA_INSTR_WIDTH,
   parameter int                     OPCODE_WIDTH = ISA_OPCODE_WIDTH,
   parameter logic [PC_WIDTH-1:0]    RESET_PC     = PC_WIDTH'(1),
   parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE = OP_HALT,
   parameter int                     CNT_WIDTH    = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic [PC_WIDTH-1:0]    rom_pc,
   input  logic [INSTR_WIDTH-1:0] rom_instr,
   input  logic                   stall,
   input  logic                   redirect,
   input  logic [PC_WIDTH-1:0]    redirect_pc,
   output logic [INSTR_WIDTH-1:0] id_instr,
   output logic [PC_WIDTH-1:0]    id_pc,
   output logic                   id_valid,
   output logic                   halted,
   output logic [CNT_WIDTH-1:0]   fetch_count
);

   fetch_state_e           state_q, state_d;
   logic [PC_WIDTH-1:0]    pc_q, pc_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   ifid_load;
   logic                   ifid_flush;
   logic                   is_halt;

   assign is_halt = (rom_instr[INSTR_WIDTH-1 -: OPCODE_WIDTH] == HALT_OPCODE);

   // State register (FSM state plus the PC and counter it controls)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= FS_RUN;
         pc_q    <= RESET_PC;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: redirect always returns to RUN, which also cancels a
   // halt fetched down a mispredicted path.
   always_comb begin
      state_d = state_q;
      if (redirect) begin
         state_d = FS_RUN;
      end else if (state_q == FS_RUN && !stall && is_halt) begin
         state_d = FS_HALTED;
      end
   end

   // Output / datapath control. HALTED is checked before stall so that a
   // stall while halted cannot hold a stale valid instruction in IF/ID.
   always_comb begin
      pc_d       = pc_q;
      cnt_d      = cnt_q;
      ifid_load  = 1'b0;
      ifid_flush = 1'b0;
      if (redirect) begin
         pc_d       = redirect_pc;
         ifid_flush = 1'b1;
      end else if (state_q == FS_HALTED) begin
         ifid_flush = 1'b1;
      end else if (!stall) begin
         ifid_load = 1'b1;
         if (cnt_q != {CNT_WIDTH{1'b1}}) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
         end
         // The halt instruction itself is delivered; the PC parks on it.
         if (!is_halt) begin
            pc_d = pc_q + PC_WIDTH'(1);
         end
      end
   end

   if_id_reg #(
      .INSTR_WIDTH (INSTR_WIDTH),
      .PC_WIDTH    (PC_WIDTH)
   ) u_if_id_reg (
      .clk     (clk),
      .reset   (reset),
      .load_i  (ifid_load),
      .flush_i (ifid_flush),
      .instr_i (rom_instr),
      .pc_i    (pc_q),
      .instr_o (id_instr),
      .pc_o    (id_pc),
      .valid_o (id_valid)
   );

   assign rom_pc      = pc_q;
   assign halted      = (state_q == FS_HALTED);
   assign fetch_count = cnt_q;

endmodule : instruction_fetch
`default_nettype wire
